mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles spent in WAIT before an access is aborted (range 2..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ctrl_mem  in  5  from execute stage; [4] reg_write, [3:2] wb_sel (00 alu, 01 load, 10 pc4, 11 alu), [1] mem_write, [0] mem_read.
REQ-005 rd_mem  in  32  destination register tag, passed through to writeback.
REQ-006 alu_result  in  32  memory byte address, or writeback value when wb_sel is alu.
REQ-007 write_data1  in  32  store data.
REQ-008 pc4_mem  in  32  link value for wb_sel 10.
REQ-009 dmem_req  out  1  data-memory request, level.
REQ-010 dmem_we  out  1  1 = store, 0 = load; meaningful only with dmem_req.
REQ-011 dmem_addr  out  32  word-aligned address, equal to alu_result.
REQ-012 dmem_wdata  out  32  equal to write_data1.
REQ-013 dmem_rdata  in  32  load data, valid when dmem_ack = 1.
REQ-014 dmem_ack  in  1  one-cycle access completion; may arrive in the same cycle as the first dmem_req.
REQ-015 stall  out  1  combinational; 1 = upstream stages hold their outputs stable.
REQ-016 ctrl_wb  out  3  registered {reg_write, wb_sel}.
REQ-017 rd_wb  out  32  registered destination tag.
REQ-018 wb_data  out  32  registered selected writeback value.
REQ-019 misalign_err  out  1  registered one-cycle pulse: misaligned memory operation.
REQ-020 bus_err  out  1  registered one-cycle pulse: access timed out.

Function
REQ-021 Memory operation (memop) = ctrl_mem[1] | ctrl_mem[0]; if both bits are set, the operation is a store (dmem_we = 1).
REQ-022 FSM states are IDLE and WAIT; reset state is IDLE.
REQ-023 IDLE, memop with alu_result[1:0] = 00: dmem_req = 1; with dmem_ack -> access completes this cycle, stall = 0, stay IDLE; without dmem_ack -> stall = 1, go to WAIT, wait counter = 1.
REQ-024 IDLE, memop with alu_result[1:0] != 00: no dmem_req, stall = 0, next-cycle ctrl_wb = 0 (bubble), misalign_err = 1 for one cycle.
REQ-025 IDLE, no memop: dmem_req = 0, stall = 0, result passes through.
REQ-026 WAIT: dmem_req = 1 with dmem_we/addr/wdata driven from the held inputs; dmem_ack -> stall = 0, access completes, go to IDLE.
REQ-027 WAIT without ack: counter increments; when the counter equals TIMEOUT, drop dmem_req, stall = 0, go to IDLE, next-cycle ctrl_wb = 0 and bus_err = 1 for one cycle.
REQ-028 dmem_ack with dmem_req = 0 SHALL be ignored.
REQ-029 Every cycle with stall = 1 SHALL load ctrl_wb = 0 (bubble); rd_wb and wb_data hold their values.
REQ-030 Every cycle with stall = 0 and no error SHALL load ctrl_wb = ctrl_mem[4:2] and rd_wb = rd_mem.
REQ-031 wb_data source: wb_sel 01 = dmem_rdata when the access is a completing load; else pc4_mem for 10; else alu_result.
REQ-032 Latency: non-memory op, 1 cycle to the WB register; load/store acked in the same cycle, 1 cycle; ack after N WAIT cycles, N+1 cycles.
REQ-033 A store SHALL never update wb_data from dmem_rdata; its wb_sel still selects alu/pc4.
REQ-034 The counter is 8 bits and SHALL not wrap, because WAIT exits at TIMEOUT.

Reset
REQ-035 While reset = 1, the next edge SHALL set: state = IDLE, counter = 0, ctrl_wb = 0, rd_wb = 0, wb_data = 0, misalign_err = 0, bus_err = 0.
REQ-036 While reset = 1, dmem_req = 0 and stall = 0 regardless of inputs; reset in WAIT abandons the access and any later ack is ignored.

Verification
REQ-037 ALU op ctrl_mem = 10000, alu_result = 0x1234 -> next cycle ctrl_wb = 100, wb_data = 0x1234, stall never 1.
REQ-038 Load ctrl_mem = 10101, addr 0x40, ack 3 cycles after first req -> stall high 3 cycles, ctrl_wb = 0 during stall, then ctrl_wb = 101 and wb_data = dmem_rdata (0xDEADBEEF).
REQ-039 Store ctrl_mem = 00010, addr 0x80, wdata 0xA5A5A5A5, same-cycle ack -> dmem_we = 1, no stall, next cycle ctrl_wb = 000.
REQ-040 Load at addr 0x42 -> no dmem_req, misalign_err pulses 1 cycle, ctrl_wb = 0.
REQ-041 Load with no ack, TIMEOUT = 16 -> stall high 16 cycles, then bus_err pulses 1 cycle, ctrl_wb = 0, state IDLE.
REQ-042 Reset asserted 2 cycles into WAIT, ack then arrives -> all outputs 0, stall = 0, ack ignored.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory port bundle between the memory stage (master) and the data memory (slave).
// Request, address and write data flow to memory; read data and the one-cycle ack flow back.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues aligned loads/stores, stalls upstream until ack or timeout,
// and registers the selected writeback value, tag and control for the writeback stage.
module mem_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ctrl_mem,
   input  logic [31:0] rd_mem,
   input  logic [31:0] alu_result,
   input  logic [31:0] write_data1,
   input  logic [31:0] pc4_mem,
   mem_stage_if.master dmem,
   output logic        stall,
   output logic [2:0]  ctrl_wb,
   output logic [31:0] rd_wb,
   output logic [31:0] wb_data,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  ctrl_wb_q, ctrl_wb_d;
   logic [31:0] rd_wb_q, rd_wb_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   logic        memop_s;
   logic        req_s;
   logic        stall_s;
   logic        complete_s;
   logic        timeout_s;
   logic        misalign_s;
   logic [31:0] sel_data_s;

   assign memop_s = ctrl_mem[1] | ctrl_mem[0];

   assign dmem.dmem_req   = req_s;
   assign dmem.dmem_we    = ctrl_mem[1];
   assign dmem.dmem_addr  = alu_result;
   assign dmem.dmem_wdata = write_data1;

   assign stall        = stall_s;
   assign ctrl_wb      = ctrl_wb_q;
   assign rd_wb        = rd_wb_q;
   assign wb_data      = wb_data_q;
   assign misalign_err = misalign_q;
   assign bus_err      = bus_err_q;

   // Access sequencing: request, stall and exit decisions; reset masks every output.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_s      = 1'b0;
      stall_s    = 1'b0;
      complete_s = 1'b0;
      timeout_s  = 1'b0;
      misalign_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (memop_s) begin
               if (alu_result[1:0] == 2'b00) begin
                  req_s = 1'b1;
                  if (dmem.dmem_ack) begin
                     complete_s = 1'b1;
                  end else begin
                     stall_s = 1'b1;
                     state_d = S_WAIT;
                     cnt_d   = 8'd1;
                  end
               end else begin
                  misalign_s = 1'b1;
               end
            end else begin
               cnt_d = 8'd0;
            end
         end
         S_WAIT: begin
            // The request is dropped in the timeout cycle so a late ack cannot complete it.
            if (cnt_q == TIMEOUT_C) begin
               timeout_s = 1'b1;
               state_d   = S_IDLE;
               cnt_d     = 8'd0;
            end else begin
               req_s = 1'b1;
               if (dmem.dmem_ack) begin
                  complete_s = 1'b1;
                  state_d    = S_IDLE;
                  cnt_d      = 8'd0;
               end else begin
                  stall_s = 1'b1;
                  cnt_d   = cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
      if (reset) begin
         state_d    = S_IDLE;
         cnt_d      = 8'd0;
         req_s      = 1'b0;
         stall_s    = 1'b0;
         complete_s = 1'b0;
         timeout_s  = 1'b0;
         misalign_s = 1'b0;
      end else begin
         state_d = state_d;
      end
   end

   // Writeback selection and bubble insertion for stalled or faulted cycles.
   always_comb begin
      sel_data_s = alu_result;
      case (ctrl_mem[3:2])
         2'b01: begin
            if (complete_s && !ctrl_mem[1]) begin
               sel_data_s = dmem.dmem_rdata;
            end else begin
               sel_data_s = alu_result;
            end
         end
         2'b10:   sel_data_s = pc4_mem;
         default: sel_data_s = alu_result;
      endcase
      ctrl_wb_d  = ctrl_wb_q;
      rd_wb_d    = rd_wb_q;
      wb_data_d  = wb_data_q;
      misalign_d = misalign_s;
      bus_err_d  = timeout_s;
      if (stall_s || misalign_s || timeout_s) begin
         ctrl_wb_d = 3'b000;
      end else begin
         ctrl_wb_d = ctrl_mem[4:2];
         rd_wb_d   = rd_mem;
         wb_data_d = sel_data_s;
      end
   end

   // State, counter and writeback registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         ctrl_wb_q  <= 3'b000;
         rd_wb_q    <= 32'd0;
         wb_data_q  <= 32'd0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ctrl_wb_q  <= ctrl_wb_d;
         rd_wb_q    <= rd_wb_d;
         wb_data_q  <= wb_data_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized transactions
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_stage;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ctrl_mem;
   logic [31:0] rd_mem, alu_result, write_data1, pc4_mem;
   logic        stall;
   logic [2:0]  ctrl_wb;
   logic [31:0] rd_wb, wb_data;
   logic        misalign_err, bus_err;

   mem_stage_if bus();

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .ctrl_mem     (ctrl_mem),
      .rd_mem       (rd_mem),
      .alu_result   (alu_result),
      .write_data1  (write_data1),
      .pc4_mem      (pc4_mem),
      .dmem         (bus),
      .stall        (stall),
      .ctrl_wb      (ctrl_wb),
      .rd_wb        (rd_wb),
      .wb_data      (wb_data),
      .misalign_err (misalign_err),
      .bus_err      (bus_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model: cycles the current access has been outstanding, plus expected WB registers
   int          m_busy  = 0;
   logic [2:0]  m_ctrl  = 3'b000;
   logic [31:0] m_rd    = 32'd0;
   logic [31:0] m_wb    = 32'd0;
   logic        m_mis   = 1'b0;
   logic        m_berr  = 1'b0;
   bit          m_known = 1'b0;
   bit          e_stall = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step(input logic rst, input logic [4:0] c, input logic [31:0] rd,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] p4,
                       input logic [31:0] rdat, input logic ack);
      bit memop, is_store, e_req, e_done, e_to, e_mis;
      @(negedge clk);
      reset          = rst;
      ctrl_mem       = c;
      rd_mem         = rd;
      alu_result     = a;
      write_data1    = wd;
      pc4_mem        = p4;
      bus.dmem_rdata = rdat;
      bus.dmem_ack   = ack;
      memop    = c[1] | c[0];
      is_store = c[1];
      e_req = 0; e_stall = 0; e_done = 0; e_to = 0; e_mis = 0;
      if (!rst && memop) begin
         if (m_busy == 0 && a[1:0] != 2'b00) e_mis = 1;
         else if (m_busy == TO) e_to = 1;
         else begin
            e_req = 1;
            if (ack) e_done = 1;
            else e_stall = 1;
         end
      end
      #1;
      chk("dmem_req", {31'd0, bus.dmem_req}, {31'd0, e_req});
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      if (e_req) begin
         chk("dmem_we", {31'd0, bus.dmem_we}, {31'd0, is_store});
         chk("dmem_addr", bus.dmem_addr, a);
         chk("dmem_wdata", bus.dmem_wdata, wd);
      end
      @(posedge clk);
      if (rst) begin
         m_busy = 0; m_ctrl = 3'b000; m_rd = 32'd0; m_wb = 32'd0;
         m_mis = 1'b0; m_berr = 1'b0; m_known = 1'b1;
      end else if (e_stall) begin
         m_busy++; m_ctrl = 3'b000; m_mis = 1'b0; m_berr = 1'b0;
      end else if (e_mis || e_to) begin
         m_busy = 0; m_ctrl = 3'b000; m_mis = e_mis; m_berr = e_to; m_known = 1'b0;
      end else begin
         m_busy = 0;
         m_ctrl = c[4:2];
         m_rd   = rd;
         if (c[3:2] == 2'b01 && e_done && !is_store) m_wb = rdat;
         else if (c[3:2] == 2'b10) m_wb = p4;
         else m_wb = a;
         m_mis = 1'b0; m_berr = 1'b0; m_known = 1'b1;
      end
      #1;
      chk("ctrl_wb", {29'd0, ctrl_wb}, {29'd0, m_ctrl});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
      chk("bus_err", {31'd0, bus_err}, {31'd0, m_berr});
      if (m_known) begin
         chk("rd_wb", rd_wb, m_rd);
         chk("wb_data", wb_data, m_wb);
      end
   endtask

   // Hold one instruction until it leaves the stage; lat = ack cycle index, -1 = never.
   task automatic txn(input logic [4:0] c, input logic [31:0] rd, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] p4, input logic [31:0] rdat,
                      input int lat);
      bit aligned_mem;
      bit done;
      int k;
      logic ack;
      aligned_mem = (c[1] | c[0]) && (a[1:0] == 2'b00);
      done = 1'b0;
      k = 0;
      while (!done && k < 64) begin
         if (aligned_mem) ack = (k == lat);
         else ack = 1'($urandom_range(0, 1));
         step(1'b0, c, rd, a, wd, p4, rdat, ack);
         done = !e_stall;
         k++;
      end
      chk("txn_done", {31'd0, done}, 32'd1);
   endtask

   initial begin
      logic [4:0]  c;
      logic [31:0] a;
      int          kind;
      int          lat;
      reset = 1'b1;
      ctrl_mem = 5'd0; rd_mem = 32'd0; alu_result = 32'd0; write_data1 = 32'd0; pc4_mem = 32'd0;
      bus.dmem_rdata = 32'd0; bus.dmem_ack = 1'b0;

      // reset state, including a presented load with ack that must be masked
      step(1'b1, 5'b00000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      step(1'b1, 5'b10101, 32'd9, 32'h40, 32'd0, 32'd0, 32'h1, 1'b1);

      txn(5'b10000, 32'd1, 32'h1234, 32'd0, 32'd0, 32'd0, -1);
      txn(5'b10101, 32'd2, 32'h40, 32'd0, 32'd0, 32'hDEADBEEF, 3);
      txn(5'b00010, 32'd3, 32'h80, 32'hA5A5A5A5, 32'd0, 32'd0, 0);
      txn(5'b10101, 32'd4, 32'h42, 32'd0, 32'd0, 32'h5555, 0);
      txn(5'b10101, 32'd5, 32'h100, 32'd0, 32'd0, 32'h7777, -1);
      txn(5'b11000, 32'd6, 32'h44, 32'd0, 32'h2000, 32'd0, -1);

      // reset two cycles into WAIT, then a stray ack
      step(1'b0, 5'b10101, 32'd7, 32'h200, 32'd0, 32'd0, 32'h1111, 1'b0);
      step(1'b0, 5'b10101, 32'd7, 32'h200, 32'd0, 32'd0, 32'h1111, 1'b0);
      step(1'b0, 5'b10101, 32'd7, 32'h200, 32'd0, 32'd0, 32'h1111, 1'b0);
      step(1'b1, 5'b10101, 32'd7, 32'h200, 32'd0, 32'd0, 32'h1111, 1'b1);
      step(1'b0, 5'b00000, 32'd8, 32'h300, 32'd0, 32'd0, 32'h2222, 1'b1);

      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 9);
         c[4]   = 1'($urandom);
         c[3:2] = 2'($urandom);
         if (kind <= 2) c[1:0] = 2'b00;
         else if (kind <= 5) c[1:0] = 2'b01;
         else if (kind <= 7) c[1:0] = 2'($urandom_range(2, 3));
         else c[1:0] = 2'($urandom_range(1, 3));
         a = $urandom;
         a[1:0] = (kind == 8) ? 2'($urandom_range(1, 3)) : 2'b00;
         lat = (kind == 9) ? -1 : $urandom_range(0, 4);
         txn(c, $urandom, a, $urandom, $urandom, $urandom, lat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
